// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of a single UART transmitter
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int DATA_WIDTH   = 8,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            lock,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            ack,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_en,
   input  logic                          tx_busy,
   output logic                          active,
   output logic                          error
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_COMPLETE,
      S_HOLD
   } state_t;

   state_t                  r_state;
   logic [IDX_W-1:0]        r_last;
   logic [IDX_W-1:0]        r_owner;
   logic [CNT_W-1:0]        r_cnt;
   logic [NUM_REQ-1:0]      r_grant;
   logic [NUM_REQ-1:0]      r_ack;
   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic                    r_tx_en;
   logic                    r_error;

   logic [2*NUM_REQ-1:0]    w_rot;
   logic                    w_any;
   logic [IDX_W-1:0]        w_sel;
   logic [DATA_WIDTH-1:0]   w_sel_data;
   logic [DATA_WIDTH-1:0]   w_owner_data;
   logic                    w_owner_req;
   logic                    w_owner_lock;

   // Rotate so bit 0 is the requester just after the last owner; lowest set bit wins.
   assign w_rot = {req, req} >> (int'(r_last) + 1);

   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_any = 1'b1;
            w_sel = IDX_W'((int'(r_last) + 1 + j) % NUM_REQ);
         end
      end
   end

   always_comb begin
      w_sel_data   = '0;
      w_owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel == IDX_W'(i)) begin
            w_sel_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
         if (r_grant[i]) begin
            w_owner_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_owner_req  = |(req & r_grant);
   assign w_owner_lock = |(lock & r_grant);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_last    <= IDX_W'(NUM_REQ - 1);
         r_owner   <= '0;
         r_cnt     <= '0;
         r_grant   <= '0;
         r_ack     <= '0;
         r_tx_data <= '0;
         r_tx_en   <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_tx_en <= 1'b0;
         r_ack   <= '0;
         case (r_state)
            S_IDLE: begin
               if (!tx_busy && w_any) begin
                  r_grant   <= NUM_REQ'(1) << w_sel;
                  r_owner   <= w_sel;
                  r_tx_data <= w_sel_data;
                  r_tx_en   <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (tx_busy) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                  // UART never picked the byte up: flag it, but still ack so the owner moves on.
                  r_error <= 1'b1;
                  r_ack   <= r_grant;
                  r_state <= S_COMPLETE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!tx_busy) begin
                  r_ack   <= r_grant;
                  r_state <= S_COMPLETE;
               end
            end
            S_COMPLETE: begin
               r_last <= r_owner;
               if (w_owner_lock) begin
                  r_state <= S_HOLD;
               end else begin
                  r_grant <= '0;
                  r_state <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (w_owner_req && !tx_busy) begin
                  r_tx_data <= w_owner_data;
                  r_tx_en   <= 1'b1;
                  r_state   <= S_ISSUE;
               end else if (!w_owner_req && !w_owner_lock) begin
                  r_grant <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant   = r_grant;
   assign ack     = r_ack;
   assign tx_data = r_tx_data;
   assign tx_en   = r_tx_en;
   assign error   = r_error;
   assign active  = (r_state != S_IDLE);

   a_grant_onehot : assert property (@(posedge clock) disable iff (!reset_n) $onehot0(r_grant));
   a_ack_owner    : assert property (@(posedge clock) disable iff (!reset_n) (r_ack & ~r_grant) == '0);
   a_tx_en_pulse  : assert property (@(posedge clock) disable iff (!reset_n) r_tx_en |=> !r_tx_en);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int NR = 3;
   localparam int DW = 8;
   localparam int BT = 64;

   logic             clock;
   logic             reset_n;
   logic [NR-1:0]    req;
   logic [NR-1:0]    lock;
   logic [NR*DW-1:0] data_in;
   logic [NR-1:0]    grant;
   logic [NR-1:0]    ack;
   logic [DW-1:0]    tx_data;
   logic             tx_en;
   logic             tx_busy;
   logic             active;
   logic             error;

   logic uart_busy;
   logic force_busy;
   logic uart_en;
   int   busy_len;
   int   u_cnt;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } tx_exp_t;

   tx_exp_t exp_tx[$];
   int      exp_ack[$];
   int      total = 0;
   int      bad   = 0;

   assign tx_busy = uart_busy | force_busy;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .DATA_WIDTH   (DW),
      .BUSY_TIMEOUT (BT)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req),
      .lock    (lock),
      .data_in (data_in),
      .grant   (grant),
      .ack     (ack),
      .tx_data (tx_data),
      .tx_en   (tx_en),
      .tx_busy (tx_busy),
      .active  (active),
      .error   (error)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endfunction

   task automatic push(input int idx, input logic [7:0] d, input bit with_ack);
      tx_exp_t e;
      e.idx  = idx;
      e.data = d;
      exp_tx.push_back(e);
      if (with_ack) exp_ack.push_back(idx);
   endtask

   task automatic wait_tx(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!tx_en && n < 300);
      if (!tx_en) begin
         total++;
         bad++;
         $display("FAIL wait_tx: no tx_en within %0d cycles", n);
      end
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (ack == '0 && n < 300);
      if (ack == '0) begin
         total++;
         bad++;
         $display("FAIL wait_ack: no ack within %0d cycles", n);
      end
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // UART model: busy rises two cycles after tx_en and stays up for busy_len cycles.
   initial begin
      uart_busy = 1'b0;
      u_cnt     = 0;
      forever begin
         @(negedge clock);
         if (u_cnt != 0) begin
            u_cnt++;
            if (u_cnt == 3) uart_busy = 1'b1;
            if (u_cnt == 3 + busy_len) begin
               uart_busy = 1'b0;
               u_cnt     = 0;
            end
         end else if (tx_en && uart_en) begin
            u_cnt = 1;
         end
      end
   end

   initial begin
      tx_exp_t e;
      int      ai;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            if (tx_en) begin
               check("tx_en_while_busy", 32'(tx_busy), 32'(0));
               if (exp_tx.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL tx_unexpected: got grant=%0h data=%0h expected no transmit", grant, tx_data);
               end else begin
                  e = exp_tx.pop_front();
                  check("tx_grant", 32'(grant), 32'(1) << e.idx);
                  check("tx_data", 32'(tx_data), 32'(e.data));
               end
            end
            if (ack != '0) begin
               if (exp_ack.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL ack_unexpected: got ack=%0h expected none", ack);
               end else begin
                  ai = exp_ack.pop_front();
                  check("ack", 32'(ack), 32'(1) << ai);
               end
            end
         end
      end
   end

   initial begin
      int n;
      reset_n    = 1'b0;
      req        = '0;
      lock       = '0;
      data_in    = '0;
      force_busy = 1'b0;
      uart_en    = 1'b1;
      busy_len   = 10;
      repeat (2) @(negedge clock);
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_tx_data", 32'(tx_data), 32'(0));
      check("rst_tx_en", 32'(tx_en), 32'(0));
      check("rst_active", 32'(active), 32'(0));
      check("rst_error", 32'(error), 32'(0));
      reset_n = 1'b1;
      @(negedge clock);

      // single request
      data_in[7:0] = 8'hA5;
      req          = 3'b001;
      push(0, 8'hA5, 1'b1);
      wait_tx(n);
      check("single_latency", 32'(n), 32'(1));
      wait_ack(n);
      check("single_ack_delay", 32'(n), 32'(13));
      req = '0;
      @(negedge clock);
      check("single_idle_active", 32'(active), 32'(0));
      check("single_idle_grant", 32'(grant), 32'(0));

      // burst lock on requester 1 while 0 and 2 wait
      busy_len = 4;
      data_in  = {8'h30, 8'h01, 8'h10};
      lock     = 3'b010;
      req      = 3'b111;
      for (int b = 1; b <= 4; b++) push(1, 8'(b), 1'b1);
      push(2, 8'h30, 1'b1);
      for (int b = 1; b <= 4; b++) begin
         wait_ack(n);
         if (b < 4) begin
            data_in[15:8] = 8'(b + 1);
         end else begin
            lock   = '0;
            req[1] = 1'b0;
         end
      end
      wait_ack(n);
      req = '0;

      // round robin, pointer sits at 2
      @(negedge clock);
      data_in = {8'h30, 8'h20, 8'h10};
      req     = 3'b111;
      for (int r = 0; r < 6; r++) push(r % 3, 8'(8'h10 * (r % 3 + 1)), 1'b1);
      for (int r = 0; r < 6; r++) wait_ack(n);
      req = '0;

      // busy timeout
      @(negedge clock);
      check("error_before_timeout", 32'(error), 32'(0));
      uart_en        = 1'b0;
      data_in[23:16] = 8'h5A;
      req            = 3'b100;
      push(2, 8'h5A, 1'b1);
      wait_tx(n);
      check("timeout_latency", 32'(n), 32'(1));
      wait_ack(n);
      check("timeout_ack_delay", 32'(n), 32'(BT + 1));
      req = '0;
      @(negedge clock);
      check("error_set", 32'(error), 32'(1));
      uart_en      = 1'b1;
      data_in[7:0] = 8'hC3;
      req          = 3'b001;
      push(0, 8'hC3, 1'b1);
      wait_tx(n);
      wait_ack(n);
      req = '0;
      @(negedge clock);
      check("error_sticky", 32'(error), 32'(1));

      // busy at idle
      force_busy   = 1'b1;
      data_in[7:0] = 8'hA5;
      req          = 3'b001;
      repeat (6) @(negedge clock);
      check("busy_idle_grant", 32'(grant), 32'(0));
      check("busy_idle_active", 32'(active), 32'(0));
      push(0, 8'hA5, 1'b1);
      force_busy = 1'b0;
      wait_tx(n);
      check("busy_release_latency", 32'(n), 32'(1));
      wait_ack(n);
      req = '0;

      // reset during WAIT_DONE
      @(negedge clock);
      busy_len      = 10;
      data_in[15:8] = 8'h77;
      req           = 3'b010;
      push(1, 8'h77, 1'b0);
      wait_tx(n);
      repeat (5) @(negedge clock);
      check("pre_reset_active", 32'(active), 32'(1));
      reset_n = 1'b0;
      #1;
      check("arst_grant", 32'(grant), 32'(0));
      check("arst_ack", 32'(ack), 32'(0));
      check("arst_tx_en", 32'(tx_en), 32'(0));
      check("arst_tx_data", 32'(tx_data), 32'(0));
      check("arst_active", 32'(active), 32'(0));
      check("arst_error", 32'(error), 32'(0));
      data_in[7:0]  = 8'h11;
      data_in[15:8] = 8'h22;
      req           = 3'b011;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      push(0, 8'h11, 1'b1);
      push(1, 8'h22, 1'b1);
      wait_ack(n);
      req = 3'b010;
      wait_ack(n);
      req = '0;

      repeat (3) @(negedge clock);
      check("tx_queue_drained", 32'(exp_tx.size()), 32'(0));
      check("ack_queue_drained", 32'(exp_ack.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
